seq_bit_serializer: RTL and testbench
=====================================

Name: seq_bit_serializer

Overview:
- Parallel-to-serial stage directly upstream of the 1011 sequence detector.
- Accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per enabled cycle onto a single serial line, which drives the detector's inp_bit.
- A one-word holding register lets consecutive words stream with no idle bit between them.
- When no word is in flight, the line carries a fixed fill value so the detector always samples a defined level.

Parameters:
- WIDTH, 8: bits per input word, minimum 2.
- MSB_FIRST, 1: 1 = shift out bit WIDTH-1 first; 0 = bit 0 first.
- FILL_BIT, 0: level driven on bit_out while no word is shifting.
- CNT_W, 16: width of the words_sent counter.

Ports:
- clk, input, 1: single clock, rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- in_data, input, WIDTH: word to serialize.
- in_valid, input, 1: in_data is valid.
- in_ready, output, 1: block can accept a word this cycle.
- bit_en, input, 1: shift enable / rate strobe; one bit advances per cycle with bit_en=1.
- bit_out, output, 1: serial bit; connects to the detector's inp_bit.
- bit_valid, output, 1: bit_out carries word data (not fill).
- word_done, output, 1: one-cycle pulse when the last bit of a word is consumed.
- busy, output, 1: high when state is SHIFT or hold_full=1.
- words_sent, output, CNT_W: count of completed words; wraps modulo 2^CNT_W.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Internal state: shift register sh (WIDTH bits), bit counter cnt (ceil(log2 WIDTH) bits), holding register hold plus flag hold_full, FSM state in {IDLE, SHIFT}.
- Reset (reset_n=0, asynchronous):
  - state=IDLE, hold_full=0, sh=0, cnt=0, words_sent=0.
  - Outputs: in_ready=1, bit_out=FILL_BIT, bit_valid=0, word_done=0, busy=0.
  - A reset mid-word discards the partial word and any held word; no word_done is issued.
- Handshake:
  - in_ready = !hold_full, combinational from registered state.
  - Accept occurs on a rising edge with in_valid=1 and in_ready=1; in_data is captured into hold and hold_full sets.
  - in_data may change freely when not accepted.
- bit_out / bit_valid (combinational from registers):
  - SHIFT: bit_out = sh[WIDTH-1] if MSB_FIRST=1, else sh[0]; bit_valid=1.
  - IDLE: bit_out=FILL_BIT, bit_valid=0.
- IDLE:
  - If hold_full=1, load sh<=hold, cnt<=0, clear hold_full, go to SHIFT. This happens regardless of bit_en.
  - Latency: accept at edge N, load at edge N+1, first data bit on bit_out in the cycle after N+1.
- SHIFT, bit_en=0: everything holds and the current bit stays on bit_out.
- SHIFT, bit_en=1, cnt<WIDTH-1: shift sh toward the output end (zero-fill), cnt+1.
- SHIFT, bit_en=1, cnt==WIDTH-1 (last bit consumed at this edge):
  - word_done=1 for the following cycle; words_sent+1, wrapping.
  - If hold_full=1: load sh<=hold, cnt<=0, clear hold_full, stay in SHIFT. This gives zero bubble between words.
  - Else: go to IDLE.
- Simultaneous load from hold and new accept on the same edge: the hold is both emptied and refilled, so hold_full stays 1 and hold takes the new in_data. in_ready was 0 that cycle, so this cannot occur; the bench asserts it never happens.
- A word accepted on the same edge as the last bit is not visible to the load decision; IDLE loads it one edge later, costing one fill cycle.
- word_done is registered: high exactly one cycle per completed word.

Test Plan:
- Single word, WIDTH=8, MSB_FIRST=1, bit_en=1, in_data=8'hB0 accepted at edge 0:
  - bit_out=FILL for cycle 0–1.
  - Bits 1,0,1,1,0,0,0,0 with bit_valid=1 over the next 8 cycles.
  - word_done pulses once; words_sent=1; detector's seq_seen asserts once.
- Back-to-back 8'hA5 then 8'h3C, in_valid held high:
  - 16 contiguous valid bits 10100101 00111100 with no gap.
  - in_ready low while hold_full; two word_done pulses; words_sent=2.
- bit_en=1 on alternate cycles, in_data=8'hF0: each bit held 2 cycles; word_done after 16 cycles of SHIFT; bit sequence unchanged.
- MSB_FIRST=0, in_data=8'h0D: bits 1,0,1,1,0,0,0,0.
- reset_n pulled low after 3 bits of 8'hFF with a second word held:
  - Immediately bit_valid=0, bit_out=FILL, in_ready=1, words_sent=0.
  - After release, no residual bits are emitted.
- CNT_W=4, 17 words streamed: words_sent reads 15 after word 15, 0 after word 16, 1 after word 17.

Source files
------------

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial stage feeding the 1011 sequence detector's inp_bit.
// A one-word holding register lets consecutive words stream with no idle bit between them.
module seq_bit_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MSB_FIRST = 1,
  parameter int unsigned FILL_BIT  = 0,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             bit_en,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             word_done,
  output logic             busy,
  output logic [CNT_W-1:0] words_sent
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic FILL = 1'(FILL_BIT);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_sh;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_hold;
  logic             r_hold_full;
  logic             r_word_done;
  logic [CNT_W-1:0] r_words_sent;

  logic [0:0]       w_state_nxt;
  logic [WIDTH-1:0] w_sh_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [WIDTH-1:0] w_hold_nxt;
  logic             w_hold_full_nxt;
  logic             w_word_done_nxt;
  logic [CNT_W-1:0] w_words_sent_nxt;
  logic             w_accept;
  logic             w_tap;
  logic [WIDTH-1:0] w_sh_shifted;

  assign w_accept = in_valid && !r_hold_full;

  // Output end of the shift register and the word after one bit has left it.
  always_comb begin
    if (MSB_FIRST != 0) begin
      w_tap        = r_sh[WIDTH-1];
      w_sh_shifted = {r_sh[WIDTH-2:0], 1'b0};
    end else begin
      w_tap        = r_sh[0];
      w_sh_shifted = {1'b0, r_sh[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_sh         <= '0;
      r_cnt        <= '0;
      r_hold       <= '0;
      r_hold_full  <= 1'b0;
      r_word_done  <= 1'b0;
      r_words_sent <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_sh         <= w_sh_nxt;
      r_cnt        <= w_cnt_nxt;
      r_hold       <= w_hold_nxt;
      r_hold_full  <= w_hold_full_nxt;
      r_word_done  <= w_word_done_nxt;
      r_words_sent <= w_words_sent_nxt;
    end
  end

  // Load from hold when idle or at the last bit; otherwise shift on each enabled cycle.
  always_comb begin
    w_state_nxt      = r_state;
    w_sh_nxt         = r_sh;
    w_cnt_nxt        = r_cnt;
    w_hold_nxt       = r_hold;
    w_hold_full_nxt  = r_hold_full;
    w_word_done_nxt  = 1'b0;
    w_words_sent_nxt = r_words_sent;

    case (r_state)
      S_IDLE: begin
        if (r_hold_full) begin
          w_sh_nxt        = r_hold;
          w_cnt_nxt       = '0;
          w_hold_full_nxt = 1'b0;
          w_state_nxt     = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (bit_en) begin
          if (r_cnt == LAST_CNT) begin
            w_word_done_nxt  = 1'b1;
            w_words_sent_nxt = r_words_sent + CNT_W'(1);
            if (r_hold_full) begin
              w_sh_nxt        = r_hold;
              w_cnt_nxt       = '0;
              w_hold_full_nxt = 1'b0;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_sh_nxt  = w_sh_shifted;
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // A new word refills hold after any load above has emptied it.
    if (w_accept) begin
      w_hold_nxt      = in_data;
      w_hold_full_nxt = 1'b1;
    end
  end

  assign in_ready   = !r_hold_full;
  assign bit_valid  = (r_state == S_SHIFT);
  assign bit_out    = (r_state == S_SHIFT) ? w_tap : FILL;
  assign busy       = (r_state == S_SHIFT) || r_hold_full;
  assign word_done  = r_word_done;
  assign words_sent = r_words_sent;

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Scoreboard bench for seq_bit_serializer: two instances (MSB-first/fill 0/4-bit counter
// and LSB-first/fill 1/16-bit counter) share one stimulus stream.
module tb_seq_bit_serializer;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         bit_en;

  logic        a_ready, a_bout, a_bval, a_done, a_busy;
  logic [3:0]  a_sent;
  logic        b_ready, b_bout, b_bval, b_done, b_busy;
  logic [15:0] b_sent;

  int errors = 0;
  int checks = 0;
  int en_mode = 0;

  // Expected serial stream per instance: {last_bit_of_word, bit}
  logic [1:0]  qa[$];
  logic [1:0]  qb[$];
  logic        pend_done;
  int unsigned model_words;

  seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(1), .FILL_BIT(0), .CNT_W(4)) u_a (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(a_ready), .bit_en(bit_en), .bit_out(a_bout), .bit_valid(a_bval),
    .word_done(a_done), .busy(a_busy), .words_sent(a_sent)
  );

  seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(0), .FILL_BIT(1), .CNT_W(16)) u_b (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(b_ready), .bit_en(bit_en), .bit_out(b_bout), .bit_valid(b_bval),
    .word_done(b_done), .busy(b_busy), .words_sent(b_sent)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (en_mode)
      0:       bit_en = 1'b1;
      1:       bit_en = ~bit_en;
      default: bit_en = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: compare every presented bit with the model, then record newly accepted words.
  always @(negedge clk) begin : monitor
    logic [1:0] e;
    if (!reset_n) begin
      qa.delete();
      qb.delete();
      pend_done   = 1'b0;
      model_words = 0;
    end else begin
      chk("word_done_a", 32'(a_done), 32'(pend_done));
      chk("word_done_b", 32'(b_done), 32'(pend_done));
      chk("words_sent_a", 32'(a_sent), 32'(4'(model_words)));
      chk("words_sent_b", 32'(b_sent), 32'(16'(model_words)));
      chk("busy_a", 32'(a_busy), 32'(qa.size() != 0));
      chk("busy_b", 32'(b_busy), 32'(qb.size() != 0));
      chk("bit_valid_ab", 32'(a_bval), 32'(b_bval));
      pend_done = 1'b0;
      if (a_bval) begin
        if (qa.size() == 0) chk("unexpected_bit_a", 32'(a_bval), 32'(0));
        else begin
          chk("bit_a", 32'(a_bout), 32'(qa[0][0]));
          if (bit_en) begin
            e = qa.pop_front();
            if (e[1]) begin
              pend_done   = 1'b1;
              model_words = model_words + 1;
            end
          end
        end
      end else begin
        chk("fill_a", 32'(a_bout), 32'(0));
      end
      if (b_bval) begin
        if (qb.size() == 0) chk("unexpected_bit_b", 32'(b_bval), 32'(0));
        else begin
          chk("bit_b", 32'(b_bout), 32'(qb[0][0]));
          if (bit_en) e = qb.pop_front();
        end
      end else begin
        chk("fill_b", 32'(b_bout), 32'(1));
      end
      if (in_valid && a_ready) begin
        chk("ready_ab", 32'(b_ready), 32'(1));
        chk("accept_while_held", 32'(u_a.r_hold_full), 32'(0));
        for (int i = 0; i < int'(W); i++) begin
          qa.push_back({1'(i == int'(W) - 1), in_data[W-1-i]});
          qb.push_back({1'(i == int'(W) - 1), in_data[i]});
        end
      end
    end
  end

  task automatic send(input logic [W-1:0] w);
    int   n;
    logic acc;
    n   = 0;
    acc = 1'b0;
    in_valid = 1'b1;
    in_data  = w;
    do begin
      @(negedge clk);
      acc = a_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 200);
    if (!acc) chk("send_timeout", 32'(acc), 32'(1));
    in_valid = 1'b0;
    in_data  = W'($urandom);
  endtask

  // One word from idle: exact latency, bit order on both instances, word_done timing.
  task automatic run_single(input logic [W-1:0] w, input logic [W-1:0] exp_a,
                            input logic [W-1:0] exp_b);
    logic [W-1:0] sa, sb;
    sa = '0;
    sb = '0;
    send(w);
    #1;
    chk("single_fill_after_accept", 32'(a_bval), 32'(0));
    chk("single_fill_level", 32'(a_bout), 32'(0));
    @(posedge clk); #2;
    for (int i = 0; i < int'(W); i++) begin
      chk("single_valid", 32'(a_bval), 32'(1));
      sa = {sa[W-2:0], a_bout};
      sb = {sb[W-2:0], b_bout};
      @(posedge clk); #2;
    end
    chk("single_seq_a", 32'(sa), 32'(exp_a));
    chk("single_seq_b", 32'(sb), 32'(exp_b));
    chk("single_done_pulse", 32'(a_done), 32'(1));
    chk("single_idle_after", 32'(a_bval), 32'(0));
    @(posedge clk); #2;
    chk("single_done_one_cycle", 32'(a_done), 32'(0));
  endtask

  task automatic measure(input int ncyc, output int longest, output int runs,
                         output int dones, output logic first_en);
    int   cur;
    logic prev;
    longest  = 0;
    runs     = 0;
    dones    = 0;
    first_en = 1'b0;
    cur      = 0;
    prev     = 1'b0;
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk); #2;
      if (a_bval) begin
        if (!prev) begin
          runs++;
          if (runs == 1) first_en = bit_en;
        end
        cur++;
        if (cur > longest) longest = cur;
      end else begin
        cur = 0;
      end
      if (a_done) dones++;
      prev = a_bval;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    en_mode  = 0;
    in_valid = 1'b0;
    while ((a_busy || qa.size() != 0 || a_done) && n < 300) begin
      @(posedge clk); #2;
      n++;
    end
    chk("drain_complete", 32'(a_busy), 32'(0));
    chk("drain_queue_empty", 32'(qa.size()), 32'(0));
  endtask

  int   longest, runs, dones, vcnt;
  logic first_en;

  initial begin
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    bit_en   = 1'b0;
    #3;
    chk("rst_ready", 32'(a_ready), 32'(1));
    chk("rst_bit_valid", 32'(a_bval), 32'(0));
    chk("rst_bit_out_a", 32'(a_bout), 32'(0));
    chk("rst_bit_out_b", 32'(b_bout), 32'(1));
    chk("rst_busy", 32'(a_busy), 32'(0));
    chk("rst_word_done", 32'(a_done), 32'(0));
    chk("rst_words_sent", 32'(b_sent), 32'(0));
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;

    en_mode = 0;
    @(posedge clk); #1;
    run_single(8'hB0, 8'hB0, 8'h0D);
    run_single(8'h0D, 8'h0D, 8'hB0);

    // Back-to-back words with in_valid held high.
    fork
      begin
        send(8'hA5);
        send(8'h3C);
        #1;
        chk("b2b_ready_low_while_held", 32'(a_ready), 32'(0));
      end
      measure(40, longest, runs, dones, first_en);
    join
    chk("b2b_contiguous_bits", 32'(longest), 32'(16));
    chk("b2b_single_run", 32'(runs), 32'(1));
    chk("b2b_done_pulses", 32'(dones), 32'(2));

    // Alternate-cycle enable: each bit after the first spans two cycles.
    en_mode = 1;
    fork
      send(8'hF0);
      measure(40, longest, runs, dones, first_en);
    join
    chk("alt_shift_cycles", 32'(longest), 32'(first_en ? 2 * W - 1 : 2 * W));
    chk("alt_done_pulses", 32'(dones), 32'(1));
    drain();

    // Reset mid-word with a second word held.
    send(8'hFF);
    send(8'h55);
    @(posedge clk);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk("midrst_bit_valid", 32'(a_bval), 32'(0));
    chk("midrst_fill_a", 32'(a_bout), 32'(0));
    chk("midrst_fill_b", 32'(b_bout), 32'(1));
    chk("midrst_ready", 32'(a_ready), 32'(1));
    chk("midrst_busy", 32'(a_busy), 32'(0));
    chk("midrst_sent_a", 32'(a_sent), 32'(0));
    chk("midrst_sent_b", 32'(b_sent), 32'(0));
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    vcnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #2;
      if (a_bval || b_bval || a_done) vcnt++;
    end
    chk("midrst_no_residual", 32'(vcnt), 32'(0));

    // Seventeen words wrap the 4-bit counter.
    for (int i = 0; i < 17; i++) send(W'($urandom));
    drain();
    chk("wrap_sent_a", 32'(a_sent), 32'(1));
    chk("wrap_sent_b", 32'(b_sent), 32'(17));

    // Random traffic and random enable.
    en_mode = 2;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      in_valid = ($urandom_range(0, 2) != 0);
      in_data  = W'($urandom);
    end
    in_valid = 1'b0;
    drain();
    chk("final_sent_b", 32'(b_sent), 32'(16'(model_words)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
